// File: rtl/dispatch_stage.sv
// Purpose : RV32I decode/dispatch latch between the IQ and the ALU/LS/branch RSs and ROB.
// Latency : one cycle from IQ accept to the earliest dispatch strobe.
// Backpres: the stage holds one instruction and stalls on its class's resources.
//           While stalled it snoops the CDB, and it only takes the IQ head when the latch frees up.
// Ports   : iq_* in / iq_ready out; rs*_idx out, rs*_val/_v/_tag in (regfile); cdb_* in;
//           *_full, *_widx, br_resolve, flush in; *_load strobes, operands, tags, opcodes,
//           rsidx, trap, br_inflight, br_total out.
module dispatch_stage #(
  parameter int ALU_RS_SIZE  = 8,
  parameter int ALU_RS_IDX_W = 3,
  parameter int LS_RS_IDX_W  = 3,
  parameter int ROB_IDX_W    = 4,
  parameter int MAX_BR       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iq_valid,
  input  logic [31:0]             iq_inst,
  input  logic [31:0]             iq_pc,
  output logic                    iq_ready,
  output logic [4:0]              rs1_idx,
  output logic [4:0]              rs2_idx,
  input  logic [31:0]             rs1_val,
  input  logic [31:0]             rs2_val,
  input  logic                    rs1_v,
  input  logic                    rs2_v,
  input  logic [ROB_IDX_W-1:0]    rs1_tag,
  input  logic [ROB_IDX_W-1:0]    rs2_tag,
  input  logic                    cdb_valid,
  input  logic [ROB_IDX_W-1:0]    cdb_tag,
  input  logic [31:0]             cdb_data,
  input  logic                    alu_full,
  input  logic                    ls_full,
  input  logic                    rob_full,
  input  logic [ALU_RS_IDX_W-1:0] alu_widx,
  input  logic [LS_RS_IDX_W-1:0]  ls_widx,
  input  logic                    br_resolve,
  input  logic                    flush,
  output logic                    alu_load,
  output logic                    ls_load,
  output logic                    br_load,
  output logic                    rob_load,
  output logic [31:0]             op_a,
  output logic [31:0]             op_b,
  output logic [31:0]             imm,
  output logic [31:0]             pc,
  output logic [31:0]             pc_base,
  output logic                    v1,
  output logic                    v2,
  output logic                    v3,
  output logic [ROB_IDX_W-1:0]    tag1,
  output logic [ROB_IDX_W-1:0]    tag2,
  output logic [4:0]              rd,
  output logic [31:0]             rsidx,
  output logic [2:0]              aluop,
  output logic [2:0]              memop,
  output logic [2:0]              cmpop,
  output logic                    trap,
  output logic [2:0]              br_inflight,
  output logic [31:0]             br_total
);

  typedef enum logic [2:0] {CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BR, CLS_JUMP, CLS_ILL} cls_t;
  typedef enum logic {ST_RUN, ST_TRAP} state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  state_t      state, state_nxt;
  logic        lat_vld;
  cls_t        lat_cls;

  // decode of the IQ head
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        r1_ok, r2_ok;
  logic [31:0] r1_dat, r2_dat;

  cls_t        d_cls;
  logic [31:0] d_op_a, d_op_b, d_imm, d_pc_base;
  logic        d_v1, d_v2, d_v3;
  logic [4:0]  d_rd;
  logic [2:0]  d_aluop, d_memop, d_cmpop;

  logic        req_met, fire, accept, br_inc, br_dec;

  assign opc     = iq_inst[6:0];
  assign f3      = iq_inst[14:12];
  assign rs1_idx = iq_inst[19:15];
  assign rs2_idx = iq_inst[24:20];

  assign imm_i = {{20{iq_inst[31]}}, iq_inst[31:20]};
  assign imm_s = {{20{iq_inst[31]}}, iq_inst[31:25], iq_inst[11:7]};
  assign imm_b = {{19{iq_inst[31]}}, iq_inst[31], iq_inst[7], iq_inst[30:25], iq_inst[11:8], 1'b0};
  assign imm_u = {iq_inst[31:12], 12'h000};
  assign imm_j = {{11{iq_inst[31]}}, iq_inst[31], iq_inst[19:12], iq_inst[20], iq_inst[30:21], 1'b0};

  // A producer broadcasting on the CDB in the accept cycle would otherwise be missed:
  // the regfile still reports it pending, and the snoop only starts next cycle.
  assign r1_ok  = rs1_v | (cdb_valid & (cdb_tag == rs1_tag));
  assign r2_ok  = rs2_v | (cdb_valid & (cdb_tag == rs2_tag));
  assign r1_dat = rs1_v ? rs1_val : cdb_data;
  assign r2_dat = rs2_v ? rs2_val : cdb_data;

  always_comb begin
    d_cls     = CLS_ILL;
    d_op_a    = '0;
    d_op_b    = '0;
    d_imm     = '0;
    d_pc_base = '0;
    d_v1      = 1'b1;
    d_v2      = 1'b1;
    d_v3      = 1'b1;
    d_rd      = '0;
    d_aluop   = '0;
    d_memop   = '0;
    d_cmpop   = '0;
    case (opc)
      OPC_LUI: begin
        d_cls = CLS_ALU; d_op_b = imm_u; d_imm = imm_u; d_rd = iq_inst[11:7];
      end
      OPC_AUIPC: begin
        d_cls = CLS_ALU; d_op_a = iq_pc; d_op_b = imm_u; d_imm = imm_u; d_rd = iq_inst[11:7];
      end
      OPC_OPIMM: begin
        d_cls = CLS_ALU; d_op_a = r1_dat; d_v1 = r1_ok; d_op_b = imm_i; d_imm = imm_i;
        d_rd = iq_inst[11:7]; d_aluop = f3;
      end
      OPC_OP: begin
        d_cls = CLS_ALU; d_op_a = r1_dat; d_v1 = r1_ok; d_op_b = r2_dat; d_v2 = r2_ok;
        d_rd = iq_inst[11:7]; d_aluop = f3;
      end
      OPC_LOAD: begin
        d_cls = CLS_LOAD; d_op_a = r1_dat; d_v1 = r1_ok; d_op_b = imm_i; d_imm = imm_i;
        d_rd = iq_inst[11:7]; d_memop = f3;
      end
      OPC_STORE: begin
        d_cls = CLS_STORE; d_op_a = r1_dat; d_v1 = r1_ok; d_op_b = r2_dat; d_v2 = r2_ok;
        d_imm = imm_s; d_memop = f3;
      end
      OPC_BRANCH: begin
        d_cls = CLS_BR; d_op_a = r1_dat; d_v1 = r1_ok; d_op_b = r2_dat; d_v2 = r2_ok;
        d_imm = imm_b; d_pc_base = iq_pc; d_cmpop = f3;
      end
      OPC_JAL: begin
        d_cls = CLS_JUMP; d_op_a = iq_pc; d_op_b = 32'd4; d_imm = imm_j; d_pc_base = iq_pc;
        d_rd = iq_inst[11:7];
      end
      OPC_JALR: begin
        // target base waits on rs1; it snoops with tag1 while the link operands are ready
        d_cls = CLS_JUMP; d_op_a = iq_pc; d_op_b = 32'd4; d_imm = imm_i; d_pc_base = r1_dat;
        d_v3 = r1_ok; d_rd = iq_inst[11:7];
      end
      default: d_cls = CLS_ILL;
    endcase
  end

  always_comb begin
    req_met = 1'b0;
    case (lat_cls)
      CLS_ALU:   req_met = !alu_full && !rob_full;
      CLS_LOAD:  req_met = !ls_full && !rob_full;
      CLS_STORE: req_met = !ls_full;
      CLS_BR:    req_met = 32'(br_inflight) < MAX_BR;
      CLS_JUMP:  req_met = !alu_full && !rob_full && (32'(br_inflight) < MAX_BR);
      default:   req_met = 1'b0;
    endcase
  end

  assign fire     = !rst && !flush && lat_vld && req_met;
  assign alu_load = fire && (lat_cls == CLS_ALU || lat_cls == CLS_JUMP);
  assign rob_load = fire && (lat_cls == CLS_ALU || lat_cls == CLS_LOAD || lat_cls == CLS_JUMP);
  assign ls_load  = fire && (lat_cls == CLS_LOAD || lat_cls == CLS_STORE);
  assign br_load  = fire && (lat_cls == CLS_BR || lat_cls == CLS_JUMP);

  assign iq_ready = !rst && state == ST_RUN && !flush && (!lat_vld || fire);
  assign accept   = iq_valid && iq_ready;
  assign trap     = state == ST_TRAP;

  always_comb begin
    rsidx = '0;
    if (lat_vld) begin
      if (lat_cls == CLS_ALU || lat_cls == CLS_JUMP) rsidx = 32'(alu_widx);
      else if (lat_cls == CLS_LOAD)                  rsidx = 32'(ls_widx) + 32'(ALU_RS_SIZE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (!flush && lat_vld && lat_cls == CLS_ILL) state_nxt = ST_TRAP;
      ST_TRAP: if (flush) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  assign br_inc = br_load;
  assign br_dec = br_resolve && (br_inflight != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      lat_vld     <= 1'b0;
      lat_cls     <= CLS_ILL;
      op_a        <= '0;
      op_b        <= '0;
      imm         <= '0;
      pc          <= '0;
      pc_base     <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      tag1        <= '0;
      tag2        <= '0;
      rd          <= '0;
      aluop       <= '0;
      memop       <= '0;
      cmpop       <= '0;
      br_inflight <= '0;
      br_total    <= '0;
    end else begin
      state <= state_nxt;

      if (flush) begin
        lat_vld <= 1'b0;
      end else if (accept) begin
        lat_vld <= 1'b1;
        lat_cls <= d_cls;
        op_a    <= d_op_a;
        op_b    <= d_op_b;
        imm     <= d_imm;
        pc      <= iq_pc;
        pc_base <= d_pc_base;
        v1      <= d_v1;
        v2      <= d_v2;
        v3      <= d_v3;
        tag1    <= rs1_tag;
        tag2    <= rs2_tag;
        rd      <= d_rd;
        aluop   <= d_aluop;
        memop   <= d_memop;
        cmpop   <= d_cmpop;
      end else if (fire) begin
        lat_vld <= 1'b0;
      end else if (lat_vld && cdb_valid) begin
        if (!v1 && tag1 == cdb_tag) begin op_a    <= cdb_data; v1 <= 1'b1; end
        if (!v2 && tag2 == cdb_tag) begin op_b    <= cdb_data; v2 <= 1'b1; end
        if (!v3 && tag1 == cdb_tag) begin pc_base <= cdb_data; v3 <= 1'b1; end
      end

      if (flush) br_inflight <= '0;
      else       br_inflight <= br_inflight + {2'b00, br_inc} - {2'b00, br_dec};

      if (br_inc) br_total <= br_total + 32'd1;
    end
  end

endmodule

// File: tb/tb_dispatch_stage.sv
// Purpose : randomized self-checking bench for dispatch_stage against a transaction-level model.
// Latency : model tracks the single dispatch latch and compares every cycle.
// Backpres: resource flags, CDB, resolves and flushes are randomized each cycle.
module tb_dispatch_stage;

  localparam int ALU_RS_SIZE = 8;
  localparam int MAX_BR      = 2;
  localparam int N_CYCLES    = 4000;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JUMP = 4, K_ILL = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        iq_valid;
  logic [31:0] iq_inst, iq_pc;
  logic        iq_ready;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_val, rs2_val;
  logic        rs1_v, rs2_v;
  logic [3:0]  rs1_tag, rs2_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        alu_full, ls_full, rob_full;
  logic [2:0]  alu_widx, ls_widx;
  logic        br_resolve, flush;
  logic        alu_load, ls_load, br_load, rob_load;
  logic [31:0] op_a, op_b, imm, pc, pc_base;
  logic        v1, v2, v3;
  logic [3:0]  tag1, tag2;
  logic [4:0]  rd;
  logic [31:0] rsidx;
  logic [2:0]  aluop, memop, cmpop;
  logic        trap;
  logic [2:0]  br_inflight;
  logic [31:0] br_total;

  always #5 clk = ~clk;

  dispatch_stage #(
    .ALU_RS_SIZE(ALU_RS_SIZE), .ALU_RS_IDX_W(3), .LS_RS_IDX_W(3), .ROB_IDX_W(4), .MAX_BR(MAX_BR)
  ) dut (
    .clk(clk), .rst(rst),
    .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_ready(iq_ready),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rs1_v(rs1_v), .rs2_v(rs2_v), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_full(alu_full), .ls_full(ls_full), .rob_full(rob_full),
    .alu_widx(alu_widx), .ls_widx(ls_widx), .br_resolve(br_resolve), .flush(flush),
    .alu_load(alu_load), .ls_load(ls_load), .br_load(br_load), .rob_load(rob_load),
    .op_a(op_a), .op_b(op_b), .imm(imm), .pc(pc), .pc_base(pc_base),
    .v1(v1), .v2(v2), .v3(v3), .tag1(tag1), .tag2(tag2), .rd(rd), .rsidx(rsidx),
    .aluop(aluop), .memop(memop), .cmpop(cmpop), .trap(trap),
    .br_inflight(br_inflight), .br_total(br_total)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          cls;
    logic [31:0] op_a, op_b, imm, pc, pc_base;
    logic        v1, v2, v3;
    logic [3:0]  tag1, tag2;
    logic [4:0]  rd;
    logic [2:0]  aluop, memop, cmpop;
  } ent_t;

  // RV32I decode written from the ISA tables: immediates built by arithmetic shifts.
  function automatic ent_t decode(input logic [31:0] inst, input logic [31:0] ipc,
                                  input logic [31:0] a_val, input logic a_v, input logic [3:0] a_tag,
                                  input logic [31:0] b_val, input logic b_v, input logic [3:0] b_tag,
                                  input logic cv, input logic [3:0] ct, input logic [31:0] cd);
    ent_t e;
    int si;
    logic [31:0] sgn, ii, is, ib, iu, ij, a, b;
    logic av, bv;
    si  = int'(inst);
    ii  = si >>> 20;
    sgn = si >>> 31;
    is  = (sgn << 12) | (32'(inst[31:25]) << 5) | 32'(inst[11:7]);
    ib  = (sgn << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
    iu  = inst & 32'hFFFF_F000;
    ij  = (sgn << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
    av  = a_v || (cv && ct == a_tag);
    bv  = b_v || (cv && ct == b_tag);
    a   = a_v ? a_val : cd;
    b   = b_v ? b_val : cd;
    e = '{cls: K_ILL, op_a: 0, op_b: 0, imm: 0, pc: ipc, pc_base: 0, v1: 1, v2: 1, v3: 1,
          tag1: a_tag, tag2: b_tag, rd: 0, aluop: 0, memop: 0, cmpop: 0};
    case (inst[6:0])
      7'h37: begin e.cls = K_ALU; e.op_b = iu; e.imm = iu; e.rd = inst[11:7]; end
      7'h17: begin e.cls = K_ALU; e.op_a = ipc; e.op_b = iu; e.imm = iu; e.rd = inst[11:7]; end
      7'h13: begin e.cls = K_ALU; e.op_a = a; e.v1 = av; e.op_b = ii; e.imm = ii;
                   e.rd = inst[11:7]; e.aluop = inst[14:12]; end
      7'h33: begin e.cls = K_ALU; e.op_a = a; e.v1 = av; e.op_b = b; e.v2 = bv;
                   e.rd = inst[11:7]; e.aluop = inst[14:12]; end
      7'h03: begin e.cls = K_LOAD; e.op_a = a; e.v1 = av; e.op_b = ii; e.imm = ii;
                   e.rd = inst[11:7]; e.memop = inst[14:12]; end
      7'h23: begin e.cls = K_STORE; e.op_a = a; e.v1 = av; e.op_b = b; e.v2 = bv;
                   e.imm = is; e.memop = inst[14:12]; end
      7'h63: begin e.cls = K_BR; e.op_a = a; e.v1 = av; e.op_b = b; e.v2 = bv;
                   e.imm = ib; e.pc_base = ipc; e.cmpop = inst[14:12]; end
      7'h6F: begin e.cls = K_JUMP; e.op_a = ipc; e.op_b = 4; e.imm = ij; e.pc_base = ipc;
                   e.rd = inst[11:7]; end
      7'h67: begin e.cls = K_JUMP; e.op_a = ipc; e.op_b = 4; e.imm = ii; e.pc_base = a;
                   e.v3 = av; e.rd = inst[11:7]; end
      default: e.cls = K_ILL;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [6:0] opcs [11];
    logic [31:0] r;
    int k;
    opcs = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h7F, 7'h73};
    k = $urandom_range(0, 59);
    r = $urandom;
    if (k >= 57)      return {r[31:7], opcs[9 + (k & 1)]};
    else if (k >= 45) return {r[31:7], 7'h63};
    else              return {r[31:7], opcs[k % 9]};
  endfunction

  ent_t        m_ent;
  bit          m_vld, m_trap;
  int          m_brin;
  logic [31:0] m_brtot;
  logic [31:0] cur_inst, cur_pc;
  bit          need_new;

  initial begin
    rst = 1'b1; iq_valid = 1'b1; iq_inst = 32'h0050_0093; iq_pc = 32'h100;
    rs1_val = 0; rs2_val = 0; rs1_v = 1; rs2_v = 1; rs1_tag = 0; rs2_tag = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0; alu_full = 0; ls_full = 0; rob_full = 0;
    alu_widx = 0; ls_widx = 0; br_resolve = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_iq_ready", 32'(iq_ready), 0);
    check("rst_strobes", {28'b0, alu_load, ls_load, br_load, rob_load}, 0);
    check("rst_trap", 32'(trap), 0);
    check("rst_br_inflight", 32'(br_inflight), 0);
    check("rst_br_total", br_total, 0);
    check("rst_op_a", op_a, 0);
    check("rst_imm", imm, 0);
    check("rst_valids", {29'b0, v1, v2, v3}, 0);
    check("rst_rsidx", rsidx, 0);
    rst = 1'b0;
    m_vld = 0; m_trap = 0; m_brin = 0; m_brtot = 0; need_new = 1;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      bit req, fire, e_ready, accept, is_br;
      logic [31:0] e_rsidx;
      // drive this cycle's inputs
      if (need_new) begin
        cur_inst = gen_inst();
        cur_pc   = $urandom & 32'hFFFF_FFFC;
        need_new = 0;
      end
      iq_valid   = $urandom_range(0, 3) != 0;
      iq_inst    = cur_inst;
      iq_pc      = cur_pc;
      rs1_val    = $urandom;  rs2_val = $urandom;
      rs1_v      = $urandom_range(0, 9) < 6;
      rs2_v      = $urandom_range(0, 9) < 6;
      rs1_tag    = 4'($urandom_range(0, 3));
      rs2_tag    = 4'($urandom_range(0, 3));
      cdb_valid  = $urandom_range(0, 1) == 1;
      cdb_tag    = 4'($urandom_range(0, 3));
      cdb_data   = $urandom;
      alu_full   = $urandom_range(0, 3) == 0;
      ls_full    = $urandom_range(0, 3) == 0;
      rob_full   = $urandom_range(0, 3) == 0;
      alu_widx   = 3'($urandom);
      ls_widx    = 3'($urandom);
      br_resolve = $urandom_range(0, 9) < 2;
      flush      = m_trap ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      #1;

      // expected combinational view of the current model state
      case (m_ent.cls)
        K_ALU:   req = !alu_full && !rob_full;
        K_LOAD:  req = !ls_full && !rob_full;
        K_STORE: req = !ls_full;
        K_BR:    req = m_brin < MAX_BR;
        K_JUMP:  req = !alu_full && !rob_full && m_brin < MAX_BR;
        default: req = 0;
      endcase
      fire    = m_vld && !flush && req;
      e_ready = !m_trap && !flush && (!m_vld || fire);
      is_br   = m_ent.cls == K_BR || m_ent.cls == K_JUMP;
      check("iq_ready", 32'(iq_ready), 32'(e_ready));
      check("alu_load", 32'(alu_load), 32'(fire && (m_ent.cls == K_ALU || m_ent.cls == K_JUMP)));
      check("ls_load",  32'(ls_load),  32'(fire && (m_ent.cls == K_LOAD || m_ent.cls == K_STORE)));
      check("br_load",  32'(br_load),  32'(fire && is_br));
      check("rob_load", 32'(rob_load),
            32'(fire && (m_ent.cls == K_ALU || m_ent.cls == K_LOAD || m_ent.cls == K_JUMP)));
      check("trap", 32'(trap), 32'(m_trap));
      check("br_inflight", 32'(br_inflight), 32'(m_brin));
      check("br_total", br_total, m_brtot);
      check("rs1_idx", 32'(rs1_idx), 32'(cur_inst[19:15]));
      check("rs2_idx", 32'(rs2_idx), 32'(cur_inst[24:20]));
      if (m_vld) begin
        e_rsidx = 0;
        if (m_ent.cls == K_ALU || m_ent.cls == K_JUMP) e_rsidx = 32'(alu_widx);
        else if (m_ent.cls == K_LOAD)                  e_rsidx = 32'(ls_widx) + ALU_RS_SIZE;
        check("rsidx", rsidx, e_rsidx);
        check("valids", {29'b0, v1, v2, v3}, {29'b0, m_ent.v1, m_ent.v2, m_ent.v3});
        if (m_ent.v1) check("op_a", op_a, m_ent.op_a);
        if (m_ent.v2) check("op_b", op_b, m_ent.op_b);
        if (m_ent.v3) check("pc_base", pc_base, m_ent.pc_base);
        check("imm", imm, m_ent.imm);
        check("pc", pc, m_ent.pc);
        check("tags", {24'b0, tag1, tag2}, {24'b0, m_ent.tag1, m_ent.tag2});
        check("rd", 32'(rd), 32'(m_ent.rd));
        check("ops", {23'b0, aluop, memop, cmpop}, {23'b0, m_ent.aluop, m_ent.memop, m_ent.cmpop});
      end

      // advance the model across the coming clock edge
      accept = iq_valid && e_ready;
      if (m_trap) m_trap = !flush;
      else        m_trap = !flush && m_vld && m_ent.cls == K_ILL;
      if (flush) m_brin = 0;
      else       m_brin = m_brin + int'(fire && is_br) - int'(br_resolve && m_brin > 0);
      if (fire && is_br) m_brtot = m_brtot + 1;
      if (flush) begin
        m_vld = 0;
      end else if (accept) begin
        m_vld = 1;
        m_ent = decode(cur_inst, cur_pc, rs1_val, rs1_v, rs1_tag, rs2_val, rs2_v, rs2_tag,
                       cdb_valid, cdb_tag, cdb_data);
        need_new = 1;
      end else if (fire) begin
        m_vld = 0;
      end else if (m_vld && cdb_valid) begin
        if (!m_ent.v1 && m_ent.tag1 == cdb_tag) begin m_ent.op_a    = cdb_data; m_ent.v1 = 1; end
        if (!m_ent.v2 && m_ent.tag2 == cdb_tag) begin m_ent.op_b    = cdb_data; m_ent.v2 = 1; end
        if (!m_ent.v3 && m_ent.tag1 == cdb_tag) begin m_ent.pc_base = cdb_data; m_ent.v3 = 1; end
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dispatch_stage.md
Name: dispatch_stage

Overview:
- Registered decode/dispatch stage between the instruction queue (IQ) and the ALU, load/store and branch reservation stations (RS) and the ROB.
- Decodes RV32I, holds one decoded instruction in a dispatch latch, and snoops the CDB while the latch is stalled.
- Tracks up to MAX_BR unresolved branches instead of stalling on every branch.
- Flags illegal opcodes with a sticky trap state.

Parameters:
ALU_RS_SIZE, 8, ALU RS entries; LS RS indices are offset by this value
ALU_RS_IDX_W, 3, ALU RS index width
LS_RS_IDX_W, 3, LS RS index width
ROB_IDX_W, 4, ROB tag width
MAX_BR, 2, maximum unresolved branches in flight (1..7)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
iq_valid  in  1  IQ head valid
iq_inst  in  32  IQ head instruction
iq_pc  in  32  IQ head PC
iq_ready  out  1  stage accepts IQ head this cycle
rs1_idx, rs2_idx  out  5 each  regfile read addresses (iq_inst[19:15], [24:20])
rs1_val, rs2_val  in  32 each  regfile data
rs1_v, rs2_v  in  1 each  regfile data valid
rs1_tag, rs2_tag  in  ROB_IDX_W each  producing ROB tag when not valid
cdb_valid  in  1  CDB broadcast
cdb_tag  in  ROB_IDX_W  CDB tag
cdb_data  in  32  CDB data
alu_full, ls_full, rob_full  in  1 each  resource full flags
alu_widx  in  ALU_RS_IDX_W  next free ALU RS slot
ls_widx  in  LS_RS_IDX_W  next free LS RS slot
br_resolve  in  1  one branch resolved this cycle
flush  in  1  mispredict squash
alu_load, ls_load, br_load, rob_load  out  1 each  dispatch strobes
op_a, op_b, imm, pc, pc_base  out  32 each  dispatched operands
v1, v2, v3  out  1 each  operand valid bits
tag1, tag2  out  ROB_IDX_W each  operand tags
rd  out  5  destination register
rsidx  out  32  RS index sent to ROB (ALU: alu_widx; load: ls_widx+ALU_RS_SIZE)
aluop, memop, cmpop  out  3 each  operation codes
trap  out  1  illegal-instruction trap, sticky
br_inflight  out  3  unresolved branch count
br_total  out  32  dispatched branch/jump count

Behaviour:
- Reset: latch invalid, state RUN, br_inflight=0, br_total=0, trap=0. All strobes and data outputs are 0. iq_ready=0 while rst is high.
- Data outputs are driven from the latch. Strobes are combinational from the latch and resource flags.
- Accept: when iq_valid && iq_ready, the decoded fields, operands, valid bits and tags are captured into the latch at the clock edge.
- iq_ready = state==RUN && !flush && (!latch_valid || dispatch_fire).
- Per-class resource requirements:
  - LUI/AUIPC/OP/OP-IMM: need !alu_full && !rob_full. Fire alu_load+rob_load.
  - LOAD: need !ls_full && !rob_full. Fire ls_load+rob_load.
  - STORE: need !ls_full. Fire ls_load only; no ROB entry.
  - BRANCH: need br_inflight<MAX_BR. Fire br_load.
  - JAL/JALR: need all ALU, ROB and branch conditions. Fire alu_load+rob_load+br_load in the same cycle. Link operands are op_a=pc, op_b=4.
- dispatch_fire = latch_valid && all requirements met. Strobes are all-or-nothing: no partial dispatch.
- Operand selection:
  - Branch: op_a=rs1, op_b=rs2, pc_base=pc, v3=1.
  - JAL: pc_base=pc, v3=1.
  - JALR: pc_base=rs1_val, v3=rs1_v.
  - Immediates are sign-extended per RV32I I/S/B/U/J formats.
- CDB snoop: every cycle the latch is valid and not firing, if cdb_valid and an operand is invalid with a matching tag, that operand takes cdb_data and its valid bit is set.
  - CDB capture also applies at accept time: if the regfile reports invalid and cdb_tag matches, capture cdb_data.
- Branch counter:
  - +1 on a dispatch with br_load; −1 on br_resolve; simultaneous increment and decrement leaves it unchanged.
  - Never underflows: br_resolve at 0 is ignored.
  - br_total increments on every br_load and wraps modulo 2^32.
- flush: clears latch_valid and sets br_inflight=0. No strobes are asserted in the flush cycle. br_total is kept.
- Illegal opcode: the instruction is latched normally, then never dispatched.
  - The next cycle enters state TRAP: trap=1, iq_ready=0.
  - TRAP exits to RUN only on flush or rst; the latch is cleared.
- flush and an IQ accept in the same cycle: flush wins and the instruction is not accepted.
- Latency: one cycle from IQ accept to earliest dispatch strobe.

Test Plan:
1. ADDI x1,x0,5 with all resources free → alu_load=rob_load=1 one cycle after accept; op_b=5, v1=v2=1, rsidx=alu_widx.
2. Three BEQs back-to-back, MAX_BR=2, no resolve → first two fire br_load and br_inflight=2; third stalls with iq_ready=0. br_resolve → third fires; br_inflight stays 2.
3. ADD with rs2_v=0, tag=3, stalled on alu_full. CDB tag 3 data 0x55 → op_b=0x55, v2=1 when alu_full drops.
4. LW with ls_widx=2 → ls_load=rob_load=1, rsidx=10. SW with rob_full=1 → ls_load=1, rob_load=0.
5. Opcode 0x7F → no strobes; trap=1 from the next cycle until flush; then iq_ready returns to 1.
6. JAL stalled on rob_full; flush with br_inflight=1 → latch dropped, no strobes, br_inflight=0.
